// File: rtl/mips_pkg.sv
// Shared encodings and helpers for the MIPS multiply/divide unit.
package mips_pkg;

    localparam int unsigned XLEN_DEFAULT = 32;

    typedef enum logic [1:0] {
        OP_MULT  = 2'd0,
        OP_MULTU = 2'd1,
        OP_DIV   = 2'd2,
        OP_DIVU  = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_e;

    // Context latched at launch and consumed by the final correction step.
    typedef struct packed {
        logic is_div;
        logic neg_q;
        logic neg_r;
        logic div_zero;
    } op_ctx_t;

    function automatic logic op_is_signed(input op_e op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

    function automatic logic op_is_div(input op_e op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/mips_sign_fix.sv
// Conditional two's-complement negate of a W-bit value.
module mips_sign_fix #(
    parameter int unsigned W = 32
) (
    input  logic         neg,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout_c
);

    always_comb begin
        dout_c = neg ? (~din + W'(1)) : din;
    end

endmodule

// File: rtl/mips_mul_div.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning the HI/LO registers.
// Define MIPS_MDU_FAST_MUL_EN for a single-cycle combinational multiply path.
module mips_mul_div
    import mips_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEFAULT
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_start,
    input  logic [1:0]      i_op,
    input  logic [XLEN-1:0] i_rs,
    input  logic [XLEN-1:0] i_rt,
    input  logic            i_hi_we,
    input  logic            i_lo_we,
    input  logic [XLEN-1:0] i_wdata,
    output logic [XLEN-1:0] o_hi,
    output logic [XLEN-1:0] o_lo,
    output logic            o_busy,
    output logic            o_done
);

    localparam int unsigned CNT_W = $clog2(XLEN) + 1;
    localparam int unsigned DW    = 2 * XLEN;

    state_e          state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic [XLEN-1:0] acc_hi, acc_hi_nx;
    logic [XLEN-1:0] acc_lo, acc_lo_nx;
    logic [XLEN-1:0] opnd, opnd_nx;
    op_ctx_t         ctx, ctx_nx;
    logic [XLEN-1:0] hi_nx, lo_nx;
    logic            busy_nx, done_nx;

    op_e             op_w;
    logic            sign_a_w, sign_b_w;
    logic [XLEN-1:0] mag_a_w, mag_b_w;
    logic [DW-1:0]   prod_fix_w;
    logic [XLEN-1:0] quo_fix_w, rem_fix_w;

    logic [XLEN:0]   mul_sum_w;
    logic [XLEN:0]   div_shift_w;
    logic            div_ge_w;
    logic [XLEN-1:0] div_sub_w;

    always_comb begin
        op_w     = op_e'(i_op);
        sign_a_w = op_is_signed(op_w) & i_rs[XLEN-1];
        sign_b_w = op_is_signed(op_w) & i_rt[XLEN-1];
    end

    mips_sign_fix #(.W(XLEN)) u_mag_a (.neg(sign_a_w), .din(i_rs), .dout_c(mag_a_w));
    mips_sign_fix #(.W(XLEN)) u_mag_b (.neg(sign_b_w), .din(i_rt), .dout_c(mag_b_w));

    mips_sign_fix #(.W(DW)) u_fix_prod (
        .neg    (ctx.neg_q),
        .din    ({acc_hi, acc_lo}),
        .dout_c (prod_fix_w)
    );
    mips_sign_fix #(.W(XLEN)) u_fix_quo (.neg(ctx.neg_q), .din(acc_lo), .dout_c(quo_fix_w));
    mips_sign_fix #(.W(XLEN)) u_fix_rem (.neg(ctx.neg_r), .din(acc_hi), .dout_c(rem_fix_w));

    // One radix-2 step: shift-add multiply or restoring divide.
    always_comb begin
        mul_sum_w   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : (XLEN+1)'(0));
        div_shift_w = {acc_hi, acc_lo[XLEN-1]};
        div_ge_w    = div_shift_w >= {1'b0, opnd};
        div_sub_w   = div_shift_w[XLEN-1:0] - opnd;
    end

`ifdef MIPS_MDU_FAST_MUL_EN
    logic [DW-1:0] fast_prod_w;
    always_comb begin
        fast_prod_w = DW'(mag_a_w) * DW'(mag_b_w);
    end
`endif

    // Next-state and datapath control.
    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        acc_hi_nx = acc_hi;
        acc_lo_nx = acc_lo;
        opnd_nx   = opnd;
        ctx_nx    = ctx;
        hi_nx     = o_hi;
        lo_nx     = o_lo;
        done_nx   = 1'b0;

        unique case (state)
            S_IDLE: begin
                if (i_hi_we) hi_nx = i_wdata;
                if (i_lo_we) lo_nx = i_wdata;
                if (i_start) begin
                    ctx_nx.is_div   = op_is_div(op_w);
                    ctx_nx.neg_q    = sign_a_w ^ sign_b_w;
                    ctx_nx.neg_r    = sign_a_w;
                    ctx_nx.div_zero = (i_rt == '0);
                    cnt_nx          = CNT_W'(XLEN);
                    acc_hi_nx       = '0;
                    if (op_is_div(op_w)) begin
                        acc_lo_nx = mag_a_w;
                        opnd_nx   = mag_b_w;
                        state_nx  = S_CALC;
                    end else begin
`ifdef MIPS_MDU_FAST_MUL_EN
                        {acc_hi_nx, acc_lo_nx} = fast_prod_w;
                        opnd_nx                = mag_a_w;
                        state_nx               = S_FIX;
`else
                        acc_lo_nx = mag_b_w;
                        opnd_nx   = mag_a_w;
                        state_nx  = S_CALC;
`endif
                    end
                end
            end
            S_CALC: begin
                cnt_nx = cnt - CNT_W'(1);
                if (ctx.is_div) begin
                    if (div_ge_w) begin
                        acc_hi_nx = div_sub_w;
                        acc_lo_nx = {acc_lo[XLEN-2:0], 1'b1};
                    end else begin
                        acc_hi_nx = div_shift_w[XLEN-1:0];
                        acc_lo_nx = {acc_lo[XLEN-2:0], 1'b0};
                    end
                end else begin
                    acc_hi_nx = mul_sum_w[XLEN:1];
                    acc_lo_nx = {mul_sum_w[0], acc_lo[XLEN-1:1]};
                end
                if (cnt == CNT_W'(1)) state_nx = S_FIX;
            end
            S_FIX: begin
                // A zero divisor leaves the dividend in the remainder path, so HI returns rs.
                if (ctx.is_div) begin
                    hi_nx = rem_fix_w;
                    lo_nx = ctx.div_zero ? '1 : quo_fix_w;
                end else begin
                    {hi_nx, lo_nx} = prod_fix_w;
                end
                done_nx  = 1'b1;
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase

        busy_nx = (state_nx != S_IDLE);
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state  <= S_IDLE;
            cnt    <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
            opnd   <= '0;
            ctx    <= '0;
            o_hi   <= '0;
            o_lo   <= '0;
            o_busy <= 1'b0;
            o_done <= 1'b0;
        end else begin
            state  <= state_nx;
            cnt    <= cnt_nx;
            acc_hi <= acc_hi_nx;
            acc_lo <= acc_lo_nx;
            opnd   <= opnd_nx;
            ctx    <= ctx_nx;
            o_hi   <= hi_nx;
            o_lo   <= lo_nx;
            o_busy <= busy_nx;
            o_done <= done_nx;
        end
    end

endmodule

// File: tb/tb_mips_mul_div.sv
// Scoreboard bench for mips_mul_div: expected HI/LO queued at launch, checked on o_done.
module tb_mips_mul_div;

    localparam int unsigned XLEN = 32;
`ifdef MIPS_MDU_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = XLEN + 1;
`endif
    localparam int DIV_LAT = XLEN + 1;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    logic            clk;
    logic            rst_n;
    logic            start;
    logic [1:0]      op;
    logic [XLEN-1:0] rs, rt;
    logic            hi_we, lo_we;
    logic [XLEN-1:0] wdata;
    logic [XLEN-1:0] hi, lo;
    logic            busy, done;

    exp_t sb_q[$];
    exp_t mon_e;
    int   checks   = 0;
    int   failures = 0;

    mips_mul_div #(.XLEN(XLEN)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_start (start),
        .i_op    (op),
        .i_rs    (rs),
        .i_rt    (rt),
        .i_hi_we (hi_we),
        .i_lo_we (lo_we),
        .i_wdata (wdata),
        .o_hi    (hi),
        .o_lo    (lo),
        .o_busy  (busy),
        .o_done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [1:0] mop, input logic [31:0] a, input logic [31:0] b);
        exp_t r;
        logic signed [63:0] sa, sb, sq, sr;
        logic [63:0] p;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        case (mop)
            2'd0: p = sa * sb;
            2'd1: p = {32'd0, a} * {32'd0, b};
            2'd2: begin
                if (b == 32'd0) p = {a, 32'hFFFF_FFFF};
                else begin
                    sq = sa / sb;
                    sr = sa % sb;
                    p  = {sr[31:0], sq[31:0]};
                end
            end
            default: begin
                if (b == 32'd0) p = {a, 32'hFFFF_FFFF};
                else p = {a % b, a / b};
            end
        endcase
        r.hi = p[63:32];
        r.lo = p[31:0];
        return r;
    endfunction

    // Result monitor: every o_done pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (sb_q.size() == 0) begin
                check_eq("spurious_done", 64'(done), 64'(0));
            end else begin
                mon_e = sb_q.pop_front();
                check_eq("res_hi", 64'(hi), 64'(mon_e.hi));
                check_eq("res_lo", 64'(lo), 64'(mon_e.lo));
            end
        end
    end

    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input exp_t e, input int lat, input bit poke);
        int  k;
        int  busy_n;
        bit  seen;
        @(posedge clk); #1;
        start = 1'b1; op = o; rs = a; rt = b;
        sb_q.push_back(e);
        @(posedge clk); #1;
        start  = 1'b0;
        busy_n = (busy === 1'b1) ? 1 : 0;
        k      = 0;
        seen   = 1'b0;
        while (k < 200 && !seen) begin
            @(posedge clk); #1;
            k++;
            if (busy === 1'b1) busy_n++;
            if (done === 1'b1) seen = 1'b1;
            if (poke && k == 5) begin
                check_eq("hi_mid", 64'(hi), 64'h0000_00AA);
                lo_we = 1'b1; wdata = 32'hDEAD; start = 1'b1; op = 2'd3; rs = 32'd9; rt = 32'd0;
            end else if (poke && k == 6) begin
                lo_we = 1'b0; start = 1'b0;
                check_eq("lo_mid_ignored", 64'(lo), 64'h0);
            end
        end
        check_eq("latency", 64'(k), 64'(lat));
        check_eq("busy_cycles", 64'(busy_n), 64'(lat));
        @(posedge clk); #1;
        check_eq("done_pulse", 64'(done), 64'h0);
    endtask

    initial begin
        int k;
        logic [1:0]  ro;
        logic [31:0] ra, rb;

        rst_n = 1'b0; start = 1'b0; op = 2'd0; rs = '0; rt = '0;
        hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_hi", 64'(hi), 64'h0);
        check_eq("rst_lo", 64'(lo), 64'h0);
        check_eq("rst_busy", 64'(busy), 64'h0);
        check_eq("rst_done", 64'(done), 64'h0);
        rst_n = 1'b1;

        run_op(2'd0, 32'hFFFF_FFFE, 32'd3,        exp_t'({32'hFFFF_FFFF, 32'hFFFF_FFFA}), MUL_LAT, 1'b0);
        run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, exp_t'({32'hFFFF_FFFE, 32'h0000_0001}), MUL_LAT, 1'b0);
        run_op(2'd2, 32'hFFFF_FFF9, 32'd2,        exp_t'({32'hFFFF_FFFF, 32'hFFFF_FFFD}), DIV_LAT, 1'b0);
        run_op(2'd3, 32'd100,       32'd7,        exp_t'({32'd2, 32'd14}), DIV_LAT, 1'b0);
        run_op(2'd3, 32'h1234,      32'd0,        exp_t'({32'h1234, 32'hFFFF_FFFF}), DIV_LAT, 1'b0);
        run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, exp_t'({32'h0, 32'h8000_0000}), DIV_LAT, 1'b0);
        run_op(2'd2, 32'hFFFF_FF00, 32'd0,        exp_t'({32'hFFFF_FF00, 32'hFFFF_FFFF}), DIV_LAT, 1'b0);

        for (int i = 0; i < 8; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = (i == 5) ? 32'd0 : ((i % 2 == 0) ? $urandom : 32'($urandom_range(1, 300)));
            run_op(ro, ra, rb, model(ro, ra, rb), (ro[1] ? DIV_LAT : MUL_LAT), 1'b0);
        end

        // Abort a DIV mid-flight; HI/LO hold nonzero values from the previous ops.
        @(posedge clk); #1;
        start = 1'b1; op = 2'd2; rs = 32'd1000; rt = 32'd3;
        @(posedge clk); #1;
        start = 1'b0;
        for (k = 1; k < 10; k++) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check_eq("abort_busy", 64'(busy), 64'h0);
        check_eq("abort_hi", 64'(hi), 64'h0);
        check_eq("abort_lo", 64'(lo), 64'h0);
        check_eq("abort_done", 64'(done), 64'h0);
        repeat (40) @(posedge clk);

        // MTHI in IDLE, then MULTU with illegal mid-operation LO write and restart.
        @(posedge clk); #1;
        hi_we = 1'b1; wdata = 32'hAA;
        @(posedge clk); #1;
        hi_we = 1'b0;
        check_eq("mthi_idle", 64'(hi), 64'h0000_00AA);
        run_op(2'd1, 32'd5, 32'd5, exp_t'({32'd0, 32'd25}), MUL_LAT, 1'b1);

        // MTLO and launch in the same IDLE cycle: write lands, result then overwrites.
        @(posedge clk); #1;
        lo_we = 1'b1; wdata = 32'h5555;
        start = 1'b1; op = 2'd0; rs = 32'd6; rt = 32'd7;
        sb_q.push_back(exp_t'({32'd0, 32'd42}));
        @(posedge clk); #1;
        lo_we = 1'b0; start = 1'b0;
        check_eq("mtlo_with_start", 64'(lo), 64'h5555);
        k = 0;
        while (k < 200 && done !== 1'b1) begin
            @(posedge clk); #1;
            k++;
        end
        check_eq("mult67_latency", 64'(k), 64'(MUL_LAT));
        repeat (3) @(posedge clk);

        check_eq("sb_empty", 64'(sb_q.size()), 64'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mips_mul_div.md
Name: mips_mul_div

Overview:
- Iterative multiply/divide unit for the MIPS core, directly downstream of the register file.
- Consumes the two register-file read operands (rs, rt) and executes MULT, MULTU, DIV and DIVU into the architectural HI/LO registers it owns.
- Also serves MTHI/MTLO writes and MFHI/MFLO reads.
- The pipeline stalls on o_busy.

Parameters:
- XLEN, 32, operand width; HI/LO are each XLEN bits.
- CNT_W, $clog2(XLEN)+1, iteration counter width (derived, not overridden).

Ports:
- i_clk  in  1  clock; all state changes on its rising edge.
- i_rst_n  in  1  reset, synchronous, active-low.
- i_start  in  1  launch operation i_op on i_rs/i_rt.
- i_op  in  2  0=MULT, 1=MULTU, 2=DIV, 3=DIVU.
- i_rs  in  XLEN  operand A (dividend / multiplicand), from register-file read port 1.
- i_rt  in  XLEN  operand B (divisor / multiplier), from register-file read port 2.
- i_hi_we  in  1  MTHI write strobe.
- i_lo_we  in  1  MTLO write strobe.
- i_wdata  in  XLEN  MTHI/MTLO data.
- o_hi  out  XLEN  HI register.
- o_lo  out  XLEN  LO register.
- o_busy  out  1  operation in progress.
- o_done  out  1  one-cycle pulse: HI/LO updated with the result.

Behaviour:
- Reset (i_rst_n=0 at an edge): state=IDLE, o_hi=0, o_lo=0, o_busy=0, o_done=0, counter=0. This aborts any operation mid-flight; no partial result is written.
- States: IDLE, CALC, FIX.
  - IDLE: i_start=1 latches the operand magnitudes and the sign flags, sets counter=XLEN, and goes to CALC.
    - Sign flags are used only for MULT/DIV.
    - Magnitude = two's-complement negation when the MSB is set and the op is signed.
  - CALC: one radix-2 step per cycle; counter decrements; at counter==1 the step completes and the state goes to FIX.
    - Multiply: shift-add, 64-bit unsigned product of the magnitudes.
    - Divide: restoring, 32-bit quotient and remainder.
  - FIX: applies sign correction, writes HI/LO, goes to IDLE, and o_done=1 for that next cycle only.
- Latency: i_start sampled at edge N, HI/LO written at edge N+XLEN+1, o_done high during the cycle that follows.
- o_busy=1 in CALC and FIX, 0 in IDLE.
- Sign rules:
  - MULT: 64-bit product negated if sign(rs)^sign(rt); HI=upper, LO=lower.
  - DIV: quotient negated if sign(rs)^sign(rt); remainder takes the sign of rs.
  - LO=quotient, HI=remainder.
- Boundary cases:
  - Divide by zero (rt=0, DIV or DIVU): LO=all ones, HI=rs (original, unmodified). Full latency still applies.
  - DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0. Falls out naturally from the magnitude path; no special case.
  - i_start while o_busy=1: ignored.
  - i_hi_we/i_lo_we while o_busy=1: ignored. Upstream stalls, so this is an illegal-usage case only.
  - i_hi_we/i_lo_we in IDLE: write i_wdata at that edge. If i_start is asserted in the same cycle, the write happens and the operation also launches; the later result overwrites HI/LO.
- HI/LO hold their values in every cycle without a write.

Optional Feature:
- Macro: MIPS_MDU_FAST_MUL_EN.
- Defined:
  - MULT/MULTU compute the 64-bit product with a single-cycle combinational multiplier on the magnitudes.
  - Path is IDLE -> FIX, so o_done appears 2 cycles after i_start.
  - Divide is unchanged.
- Undefined: multiply is iterative as above, with XLEN+1 cycle latency.
- o_busy semantics are identical in both builds.

Decomposition:
- Package/header mips_pkg:
  - Op encodings OP_MULT/OP_MULTU/OP_DIV/OP_DIVU.
  - State encodings S_IDLE/S_CALC/S_FIX.
  - XLEN default.
- One sub-module, mips_sign_fix: combinational conditional two's-complement negate, parameterised width.
  - Used for operand magnitudes (XLEN) and for result correction (2*XLEN and XLEN).

Test Plan:
- MULT rs=0xFFFFFFFE (-2), rt=3 -> after 33 cycles o_done=1; HI=0xFFFFFFFF, LO=0xFFFFFFFA; o_busy high for exactly 33 cycles.
- MULTU rs=0xFFFFFFFF, rt=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
- DIV rs=-7 (0xFFFFFFF9), rt=2 -> LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1). DIVU rs=100, rt=7 -> LO=14, HI=2.
- DIVU rs=0x1234, rt=0 -> LO=0xFFFFFFFF, HI=0x1234. DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
- MTHI 0xAA in IDLE, then i_start MULTU 5*5 with i_lo_we asserted mid-operation:
  - HI=0xAA before the result.
  - The mid-operation LO write is ignored.
  - Final HI=0, LO=25.
  - A second i_start asserted mid-operation is ignored.
- i_rst_n=0 at cycle 10 of a DIV -> next cycle o_busy=0, HI=LO=0, no o_done pulse. With MIPS_MDU_FAST_MUL_EN, MULT 6*7 gives o_done 2 cycles after i_start, LO=42.
